// File: rtl/spi_bus_arbiter_pkg.sv
// Shared types and constants for the SPI bus arbiter: FSM state encoding,
// chip-select gap length and a small constant helper.
package spi_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } arb_state_e;

  // Cycles with every chip select high between two grants.
  localparam int GAP_LEN = 1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first asserted request at or after ptr,
// returned both one-hot and as an index.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               any_req
);

  int   cand;
  logic found;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the loop can leave a value unassigned and infer a latch.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    cand     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[cand]) begin
        pick[cand] = 1'b1;
        pick_idx   = IDX_W'(cand);
        found      = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin owner of one byte-level SPI engine: grants whole transactions,
// frames them with chip-select setup/hold/gap and aborts hung bytes by watchdog.
module spi_bus_arbiter
  import spi_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int TIMEOUT  = 4095
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     tx_valid,
  input  logic [NUM_REQ-1:0]     tx_last,
  input  logic [8*NUM_REQ-1:0]   tx_data,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     tx_ready,
  output logic [NUM_REQ-1:0]     rx_valid,
  output logic [7:0]             rx_data,
  output logic [NUM_REQ-1:0]     timeout_err,
  output logic [NUM_REQ-1:0]     cs_n,
  output logic [7:0]             eng_send,
  output logic                   eng_begin,
  input  logic [7:0]             eng_rx,
  input  logic                   eng_end
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(max_int(max_int(CS_SETUP, CS_HOLD), GAP_LEN) + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_LEN - 1);
  localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0]  WD_MAX     = '1;
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_REQ - 1);

  arb_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WD_W-1:0]    wd_q;
  logic [IDX_W-1:0]   ptr_q, idx_q;
  logic               last_q;

  logic [NUM_REQ-1:0] arb_pick;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;

  logic [7:0]         tx_byte;
  logic               req_sel, tx_valid_sel, tx_last_sel;
  logic               grant_en, fire, byte_done, abort, release_en;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req      (req),
    .ptr      (ptr_q),
    .pick     (arb_pick),
    .pick_idx (arb_idx),
    .any_req  (arb_any)
  );

  // Requester-side inputs of the current owner, selected by the one-hot grant.
  always_comb begin
    tx_byte      = '0;
    req_sel      = 1'b0;
    tx_valid_sel = 1'b0;
    tx_last_sel  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        tx_byte      = tx_byte | tx_data[8*i +: 8];
        req_sel      = req_sel | req[i];
        tx_valid_sel = tx_valid_sel | tx_valid[i];
        tx_last_sel  = tx_last_sel | tx_last[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_en   = 1'b0;
    fire       = 1'b0;
    byte_done  = 1'b0;
    abort      = 1'b0;
    release_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_en = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) state_d = ISSUE;
      end
      ISSUE: begin
        // A dropped request ends the transaction cleanly through HOLD.
        if (!req_sel) begin
          state_d = HOLD;
        end else if (tx_valid_sel) begin
          fire    = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (eng_end) begin
          byte_done = 1'b1;
          state_d   = last_q ? HOLD : ISSUE;
        end else if (wd_q == WD_LAST) begin
          abort   = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          release_en = 1'b1;
          state_d    = GAP;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state and outputs update with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wd_q    <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;

      // Guard-time counter restarts on every state change.
      if (state_d != state_q || !(state_q inside {SETUP, HOLD, GAP}))
        cnt_q <= '0;
      else
        cnt_q <= cnt_q + 1'b1;

      if (state_q == ISSUE)
        wd_q <= '0;
      else if (state_q == WAIT && wd_q != WD_MAX)
        wd_q <= wd_q + 1'b1;

      if (grant_en) idx_q <= arb_idx;
      if (fire) last_q <= tx_last_sel;
      if (release_en) ptr_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt         <= '0;
      cs_n        <= '1;
      tx_ready    <= '0;
      rx_valid    <= '0;
      timeout_err <= '0;
      rx_data     <= '0;
      eng_send    <= '0;
      eng_begin   <= 1'b0;
    end else begin
      tx_ready    <= fire      ? gnt : '0;
      rx_valid    <= byte_done ? gnt : '0;
      timeout_err <= abort     ? gnt : '0;
      eng_begin   <= fire;
      if (fire)      eng_send <= tx_byte;
      if (byte_done) rx_data  <= eng_rx;

      if (grant_en) begin
        gnt  <= arb_pick;
        cs_n <= ~arb_pick;
      end else if (release_en) begin
        gnt  <= '0;
        cs_n <= '1;
      end
    end
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter with an echoing engine model (rx = ~tx)
// and continuous chip-select monitors.
module tb_spi_bus_arbiter;

  localparam int K_ENG_BEGIN = 0;
  localparam int K_RX_VALID  = 1;
  localparam int K_CS_HIGH   = 2;
  localparam int K_GNT       = 3;
  localparam int K_TIMEOUT   = 4;

  logic        clk;
  logic        rst;
  logic [1:0]  req, tx_valid, tx_last;
  logic [15:0] tx_data;
  logic [1:0]  gnt, tx_ready, rx_valid, timeout_err, cs_n;
  logic [7:0]  rx_data, eng_send, eng_rx;
  logic        eng_begin, eng_end_m, stray_end;

  logic [7:0]  bytes [2][4];
  int          n_bytes [2];
  bit          last_en [2];
  int          pos [2];
  logic [1:0]  prev_req;
  bit          eng_on;

  int          eng_begin_cnt, rx_cnt [2], cs_viol, gap_viol;
  logic [1:0]  prev_cs;

  int          n_checks, n_errors;

  spi_bus_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .tx_valid    (tx_valid),
    .tx_last     (tx_last),
    .tx_data     (tx_data),
    .gnt         (gnt),
    .tx_ready    (tx_ready),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .timeout_err (timeout_err),
    .cs_n        (cs_n),
    .eng_send    (eng_send),
    .eng_begin   (eng_begin),
    .eng_rx      (eng_rx),
    .eng_end     (eng_end_m | stray_end)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic hit(input int kind, input int idx);
    case (kind)
      K_ENG_BEGIN: return eng_begin;
      K_RX_VALID:  return rx_valid[idx];
      K_CS_HIGH:   return cs_n[idx];
      K_GNT:       return gnt[idx];
      K_TIMEOUT:   return timeout_err[idx];
      default:     return 1'b0;
    endcase
  endfunction

  task automatic wait_until(input string tag, input int kind, input int idx,
                            input int budget, output int n);
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (hit(kind, idx)) break;
      if (n >= budget) begin
        check({tag, "_reached"}, 32'(hit(kind, idx)), 32'd1);
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Requester model: offers bytes while req is high, advances on tx_ready.
  initial begin
    tx_valid = '0;
    tx_last  = '0;
    tx_data  = '0;
    prev_req = '0;
    pos[0]   = 0;
    pos[1]   = 0;
    forever begin
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
        if (req[r] && !prev_req[r]) pos[r] = 0;
        else if (tx_ready[r]) pos[r]++;
        if (req[r] && pos[r] < n_bytes[r]) begin
          tx_valid[r]        = 1'b1;
          tx_data[8*r +: 8]  = bytes[r][pos[r]];
          tx_last[r]         = last_en[r] && (pos[r] == n_bytes[r] - 1);
        end else begin
          tx_valid[r] = 1'b0;
          tx_last[r]  = 1'b0;
        end
      end
      prev_req = req;
    end
  end

  // Engine model: eng_end two cycles after eng_begin, echoing the inverted byte.
  initial begin
    eng_end_m = 1'b0;
    eng_rx    = '0;
    forever begin
      @(negedge clk);
      if (eng_begin && eng_on) begin
        repeat (2) @(negedge clk);
        eng_rx    = ~eng_send;
        eng_end_m = 1'b1;
        @(negedge clk);
        eng_end_m = 1'b0;
      end
    end
  end

  // Monitors: event counters, at most one chip select low, no direct handover.
  initial begin
    eng_begin_cnt = 0;
    rx_cnt[0] = 0;
    rx_cnt[1] = 0;
    cs_viol   = 0;
    gap_viol  = 0;
    prev_cs   = '1;
    forever begin
      @(negedge clk);
      if (eng_begin) eng_begin_cnt++;
      for (int r = 0; r < 2; r++) if (rx_valid[r]) rx_cnt[r]++;
      if ($countones(~cs_n) > 1) cs_viol++;
      if (cs_n != 2'b11 && prev_cs != 2'b11 && cs_n != prev_cs) gap_viol++;
      prev_cs = cs_n;
    end
  end

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n, eb, rxs;
    n_checks  = 0;
    n_errors  = 0;
    stray_end = 1'b0;
    eng_on    = 1'b1;
    n_bytes[0] = 0;
    n_bytes[1] = 0;
    last_en[0] = 1'b1;
    last_en[1] = 1'b1;
    rst = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    check("rst_cs_n", 32'(cs_n), 32'h3);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_pulses", 32'({tx_ready, rx_valid, timeout_err, eng_begin}), 32'h0);
    check("rst_data", 32'({rx_data, eng_send}), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Single requester, three bytes.
    bytes[0][0] = 8'h20; bytes[0][1] = 8'h0F; bytes[0][2] = 8'h8F;
    n_bytes[0]  = 3;
    eb = eng_begin_cnt;
    req = 2'b01;
    @(negedge clk);
    check("t1_cs_low", 32'(cs_n), 32'h2);
    check("t1_gnt", 32'(gnt), 32'h1);
    wait_until("t1_begin", K_ENG_BEGIN, 0, 20, n);
    check("t1_setup_latency", 32'(n), 32'd5);
    check("t1_eng_send", 32'(eng_send), 32'h20);
    check("t1_tx_ready", 32'(tx_ready), 32'h1);
    wait_until("t1_rx0", K_RX_VALID, 0, 50, n);
    check("t1_rx0", 32'(rx_data), 32'hDF);
    wait_until("t1_rx1", K_RX_VALID, 0, 50, n);
    check("t1_rx1", 32'(rx_data), 32'hF0);
    wait_until("t1_rx2", K_RX_VALID, 0, 50, n);
    check("t1_rx2", 32'(rx_data), 32'h70);
    wait_until("t1_release", K_CS_HIGH, 0, 50, n);
    check("t1_hold_len", 32'(n), 32'd4);
    check("t1_begin_count", 32'(eng_begin_cnt - eb), 32'd3);
    req = 2'b00;
    repeat (4) @(negedge clk);

    // Simultaneous requests after reset, then requester 0 returns.
    do_reset();
    bytes[0][0] = 8'h11; n_bytes[0] = 1;
    bytes[1][0] = 8'h3C; bytes[1][1] = 8'h5A; n_bytes[1] = 2;
    req = 2'b11;
    @(negedge clk);
    check("t2_first_gnt", 32'(gnt), 32'h1);
    wait_until("t2_r0_rel", K_CS_HIGH, 0, 100, n);
    req[0] = 1'b0;
    check("t2_rel_cs", 32'(cs_n), 32'h3);
    check("t2_rel_gnt", 32'(gnt), 32'h0);
    @(negedge clk);
    check("t2_gap_cs", 32'(cs_n), 32'h3);
    @(negedge clk);
    check("t2_second_gnt", 32'(gnt), 32'h2);
    bytes[0][0] = 8'h77;
    req[0] = 1'b1;
    rxs = rx_cnt[1];
    wait_until("t2_r1_rel", K_CS_HIGH, 1, 100, n);
    check("t2_r1_rx_count", 32'(rx_cnt[1] - rxs), 32'd2);
    check("t2_r1_last_rx", 32'(rx_data), 32'hA5);
    check("t2_r1_rel_gnt", 32'(gnt), 32'h0);
    req[1] = 1'b0;
    wait_until("t2_r0_regnt", K_GNT, 0, 20, n);
    check("t2_r0_regnt_lat", 32'(n), 32'd2);
    wait_until("t2_r0_rx", K_RX_VALID, 0, 50, n);
    check("t2_r0_rx", 32'(rx_data), 32'h88);
    wait_until("t2_r0_done", K_CS_HIGH, 0, 50, n);
    req[0] = 1'b0;

    // Watchdog abort on requester 1 (pointer now at 1), then requester 0.
    bytes[1][0] = 8'h99; n_bytes[1] = 1;
    bytes[0][0] = 8'h01; n_bytes[0] = 1;
    eng_on = 1'b0;
    @(negedge clk);
    req = 2'b11;
    wait_until("t3_begin", K_ENG_BEGIN, 0, 20, n);
    check("t3_r1_first", 32'(gnt), 32'h2);
    rxs = rx_cnt[1];
    wait_until("t3_timeout", K_TIMEOUT, 1, 5000, n);
    check("t3_timeout_cycles", 32'(n), 32'd4095);
    check("t3_timeout_err", 32'(timeout_err), 32'h2);
    eng_on = 1'b1;
    wait_until("t3_r1_rel", K_CS_HIGH, 1, 50, n);
    check("t3_hold_len", 32'(n), 32'd4);
    check("t3_no_rx", 32'(rx_cnt[1] - rxs), 32'd0);
    req[1] = 1'b0;
    wait_until("t3_r0_gnt", K_GNT, 0, 20, n);
    check("t3_r0_gnt_lat", 32'(n), 32'd2);
    wait_until("t3_r0_rx", K_RX_VALID, 0, 50, n);
    check("t3_r0_rx", 32'(rx_data), 32'hFE);
    wait_until("t3_r0_done", K_CS_HIGH, 0, 50, n);
    req[0] = 1'b0;

    // Asynchronous reset while requester 1 waits on the engine.
    bytes[1][0] = 8'h42; n_bytes[1] = 1;
    eng_on = 1'b0;
    @(negedge clk);
    req = 2'b10;
    wait_until("t4_begin", K_ENG_BEGIN, 0, 20, n);
    repeat (2) @(negedge clk);
    check("t4_cs1_low", 32'(cs_n), 32'h1);
    #2;
    rst = 1'b0;
    req = 2'b00;
    #1;
    check("t4_async_cs", 32'(cs_n), 32'h3);
    check("t4_async_gnt", 32'(gnt), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    eng_on = 1'b1;
    bytes[0][0] = 8'hC3; n_bytes[0] = 1;
    req = 2'b11;
    @(negedge clk);
    check("t4_ptr_reset", 32'(gnt), 32'h1);
    wait_until("t4_r0_rx", K_RX_VALID, 0, 50, n);
    check("t4_r0_rx", 32'(rx_data), 32'h3C);
    wait_until("t4_r0_done", K_CS_HIGH, 0, 50, n);
    req[0] = 1'b0;
    wait_until("t4_r1_gnt", K_GNT, 1, 20, n);
    wait_until("t4_r1_rx", K_RX_VALID, 1, 50, n);
    check("t4_r1_rx", 32'(rx_data), 32'hBD);
    wait_until("t4_r1_done", K_CS_HIGH, 1, 50, n);
    req[1] = 1'b0;

    // Requester 0 drops req in ISSUE after one non-final byte.
    bytes[0][0] = 8'hA1; n_bytes[0] = 1; last_en[0] = 1'b0;
    @(negedge clk);
    req = 2'b01;
    wait_until("t5_rx", K_RX_VALID, 0, 50, n);
    check("t5_rx", 32'(rx_data), 32'h5E);
    req[0] = 1'b0;
    eb = eng_begin_cnt;
    wait_until("t5_rel", K_CS_HIGH, 0, 50, n);
    check("t5_drop_to_release", 32'(n), 32'd5);
    check("t5_no_more_begin", 32'(eng_begin_cnt - eb), 32'd0);
    last_en[0] = 1'b1;

    // Stray eng_end while idle.
    repeat (4) @(negedge clk);
    rxs = rx_cnt[0] + rx_cnt[1];
    stray_end = 1'b1;
    @(negedge clk);
    stray_end = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_stray_no_rx", 32'(rx_cnt[0] + rx_cnt[1] - rxs), 32'd0);
    check("t5_idle_cs", 32'(cs_n), 32'h3);

    check("cs_at_most_one_low", 32'(cs_viol), 32'd0);
    check("cs_gap_between_grants", 32'(gap_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
